// File: rtl/temp_sample_sched.sv
// Periodic round-robin sensor sampler: one sample per slot is accepted from the
// next eligible source and written into a DEPTH-entry ring buffer.
module temp_sample_sched #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int PERIOD  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int GW = $clog2(NUM_SRC),
  localparam int TW = $clog2(PERIOD)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_req,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      buf_wr,
  output logic [AW-1:0]             buf_addr,
  output logic [DATA_W-1:0]         buf_data,
  output logic                      buf_clear,
  output logic [GW-1:0]             grant_id,
  output logic                      window_done,
  output logic [7:0]                miss_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARB, S_WRITE, S_CLEAR} state_e;

  state_e                           state, state_nx;
  logic [NUM_SRC-1:0][DATA_W-1:0]   src_vec;
  logic [TW-1:0]                    timer;
  logic [AW-1:0]                    wr_ptr;
  logic                             clr_pend;
  logic                             arb_hit;
  logic [GW-1:0]                    arb_id;
  logic [GW-1:0]                    cand;
  int                               idx;
  logic [NUM_SRC-1:0]               ready_nx;
  logic                             wr_nx, clr_nx, done_nx;

  assign src_vec = src_data;

  // Round-robin search starting just past the last granted source.
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx  = (int'(grant_id) + k) % NUM_SRC;
      cand = GW'(idx);
      if (!arb_hit && src_valid[cand]) begin
        arb_hit = 1'b1;
        arb_id  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (enable) state_nx = (clear_req || clr_pend) ? S_CLEAR : S_WAIT;
      S_WAIT:  if (clear_req)          state_nx = S_CLEAR;
               else if (!enable)       state_nx = S_IDLE;
               else if (timer <= TW'(1)) state_nx = S_ARB;
      S_ARB:   if (clear_req)          state_nx = S_CLEAR;
               else if (!enable)       state_nx = S_IDLE;
               else if (arb_hit)       state_nx = S_WRITE;
               else                    state_nx = S_WAIT;
      S_WRITE: if (clear_req)          state_nx = S_CLEAR;
               else if (!enable)       state_nx = S_IDLE;
               else                    state_nx = S_WAIT;
      S_CLEAR: if (clear_req)          state_nx = S_CLEAR;
               else if (enable)        state_nx = S_WAIT;
               else                    state_nx = S_IDLE;
      default:                         state_nx = S_IDLE;
    endcase
  end

  // Strobes are decoded one state early so every output leaves a flop.
  always_comb begin
    ready_nx = '0;
    wr_nx    = (state_nx == S_WRITE);
    clr_nx   = (state_nx == S_CLEAR);
    done_nx  = (state == S_WRITE) && (wr_ptr == AW'(DEPTH-1));
    if (wr_nx) ready_nx[arb_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_ready   <= '0;
      buf_wr      <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      buf_clear   <= 1'b0;
      window_done <= 1'b0;
      grant_id    <= GW'(NUM_SRC-1);
      miss_cnt    <= '0;
      wr_ptr      <= '0;
      timer       <= '0;
      clr_pend    <= 1'b0;
    end else begin
      src_ready   <= ready_nx;
      buf_wr      <= wr_nx;
      buf_clear   <= clr_nx;
      window_done <= done_nx;
      if (wr_nx) begin
        buf_data <= src_vec[arb_id];
        buf_addr <= wr_ptr;
        grant_id <= arb_id;
      end
      if (state_nx == S_WAIT && state != S_WAIT) timer <= TW'(PERIOD-1);
      else if (state == S_WAIT)                  timer <= timer - TW'(1);
      if (state == S_ARB && state_nx == S_WAIT && miss_cnt != 8'hFF)
        miss_cnt <= miss_cnt + 8'd1;
      if (state == S_WRITE) wr_ptr <= wr_ptr + AW'(1);
      // A clear wins over the pointer bump of a write completing this cycle.
      if (state_nx == S_CLEAR) begin
        wr_ptr   <= '0;
        miss_cnt <= '0;
        clr_pend <= 1'b0;
      end else if (state == S_IDLE && clear_req) begin
        clr_pend <= 1'b1;
      end
    end
  end

endmodule
